// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared segment codes and scan FSM state encodings
package seg7_scan_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: digit data in, multiplexed segment/digit pins out
interface seg7_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;
  modport master (output enable, digits_in, dp_in, blank_mask, input seg, dig_en, frame_done);
  modport slave  (input enable, digits_in, dp_in, blank_mask, output seg, dig_en, frame_done);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: hex nibble to active-low segments, dp held off
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);
  assign o_seg = HEX_SEG[i_hex] | 8'h80;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: round-robin 7-segment scanner with blank gap and per-frame snapshot
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_fd;
  logic [7:0]              w_dec;
  logic [7:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_dig;
  seg7_hex_decode u_dec (.i_hex(r_digits[4*r_idx +: 4]), .o_seg(w_dec));
  assign w_seg = r_mask[r_idx] ? SEG_BLANK : {~r_dp[r_idx], 7'h7F} & w_dec;
  assign w_dig = r_mask[r_idx] ? '1 : ~(NUM_DIGITS'(1) << r_idx);
  assign bus.seg        = r_seg;
  assign bus.dig_en     = r_dig;
  assign bus.frame_done = r_fd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_digits <= '0;
      r_dp     <= '0;
      r_mask   <= '0;
      r_seg    <= SEG_BLANK;
      r_dig    <= '1;
      r_fd     <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      if (!bus.enable) begin
        r_state <= ST_IDLE;
        r_seg   <= SEG_BLANK;
        r_dig   <= '1;
      end else if (r_state == ST_IDLE) begin
        r_state  <= ST_BLANK;
        r_cnt    <= '0;
        r_idx    <= '0;
        r_digits <= bus.digits_in;
        r_dp     <= bus.dp_in;
        r_mask   <= bus.blank_mask;
      end else if (r_cnt == CNT_LAST) begin
        r_state <= ST_BLANK;
        r_cnt   <= '0;
        r_seg   <= SEG_BLANK;
        r_dig   <= '1;
        if (r_idx == IDX_LAST) begin
          r_idx    <= '0;
          r_fd     <= 1'b1;
          r_digits <= bus.digits_in;
          r_dp     <= bus.dp_in;
          r_mask   <= bus.blank_mask;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        // shadow and idx are stable for the whole slot, so latch outputs once on entry
        if (r_state == ST_BLANK && r_cnt == BLK_LAST) begin
          r_state <= ST_SHOW;
          r_seg   <= w_seg;
          r_dig   <= w_dig;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of slot timing, snapshot, mask/dp, enable and reset
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();
  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got fd/dig/seg=%h expected %h", tag, got, exp);
    end
  endtask
  task automatic now(input string tag, input logic [7:0] s, input logic [3:0] d, input logic f);
    check(tag, {19'd0, bus.frame_done, bus.dig_en, bus.seg}, {19'd0, f, d, s});
  endtask
  task automatic cyc(input string tag, input logic [7:0] s, input logic [3:0] d, input logic f);
    @(posedge clk);
    @(negedge clk);
    now(tag, s, d, f);
  endtask
  task automatic slot(input string tag, input logic [7:0] s, input logic [3:0] d, input logic f0);
    for (int i = 0; i < 8; i++)
      cyc(tag, i < 2 ? 8'hFF : s, i < 2 ? 4'hF : d, i == 0 ? f0 : 1'b0);
  endtask
  initial begin
    bus.enable     = 1'b0;
    bus.digits_in  = 16'h3A70;
    bus.dp_in      = 4'b0000;
    bus.blank_mask = 4'b0000;
    #12 now("reset", 8'hFF, 4'hF, 1'b0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc("idle", 8'hFF, 4'hF, 1'b0);
    bus.enable = 1'b1;
    slot("f1s0", 8'hC0, 4'b1110, 1'b0);
    slot("f1s1", 8'hF8, 4'b1101, 1'b0);
    slot("f1s2", 8'h88, 4'b1011, 1'b0);
    slot("f1s3", 8'hB0, 4'b0111, 1'b0);
    slot("f2s0", 8'hC0, 4'b1110, 1'b1);
    cyc("f2s1", 8'hFF, 4'hF, 1'b0);
    cyc("f2s1", 8'hFF, 4'hF, 1'b0);
    cyc("f2s1", 8'hF8, 4'b1101, 1'b0);
    cyc("f2s1", 8'hF8, 4'b1101, 1'b0);
    bus.digits_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) cyc("f2s1", 8'hF8, 4'b1101, 1'b0);
    slot("f2s2", 8'h88, 4'b1011, 1'b0);
    slot("f2s3", 8'hB0, 4'b0111, 1'b0);
    slot("f3s0", 8'h8E, 4'b1110, 1'b1);
    bus.digits_in  = 16'h3A70;
    bus.dp_in      = 4'b0010;
    bus.blank_mask = 4'b1000;
    slot("f3s1", 8'h8E, 4'b1101, 1'b0);
    slot("f3s2", 8'h8E, 4'b1011, 1'b0);
    slot("f3s3", 8'h8E, 4'b0111, 1'b0);
    slot("f4s0", 8'hC0, 4'b1110, 1'b1);
    slot("f4s1", 8'h78, 4'b1101, 1'b0);
    slot("f4s2", 8'h88, 4'b1011, 1'b0);
    slot("f4s3", 8'hFF, 4'b1111, 1'b0);
    slot("f5s0", 8'hC0, 4'b1110, 1'b1);
    slot("f5s1", 8'h78, 4'b1101, 1'b0);
    cyc("f5s2", 8'hFF, 4'hF, 1'b0);
    cyc("f5s2", 8'hFF, 4'hF, 1'b0);
    cyc("f5s2", 8'h88, 4'b1011, 1'b0);
    cyc("f5s2", 8'h88, 4'b1011, 1'b0);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc("drop", 8'hFF, 4'hF, 1'b0);
    bus.enable = 1'b1;
    slot("re_s0", 8'hC0, 4'b1110, 1'b0);
    slot("re_s1", 8'h78, 4'b1101, 1'b0);
    slot("re_s2", 8'h88, 4'b1011, 1'b0);
    slot("re_s3", 8'hFF, 4'b1111, 1'b0);
    bus.enable = 1'b0;
    cyc("drop_at_end", 8'hFF, 4'hF, 1'b0);
    cyc("drop_at_end", 8'hFF, 4'hF, 1'b0);
    bus.dp_in      = 4'b0000;
    bus.blank_mask = 4'b0000;
    bus.enable     = 1'b1;
    cyc("pre_rst", 8'hFF, 4'hF, 1'b0);
    cyc("pre_rst", 8'hFF, 4'hF, 1'b0);
    cyc("pre_rst", 8'hC0, 4'b1110, 1'b0);
    #2 rst = 1'b1;
    #1 now("async_rst", 8'hFF, 4'hF, 1'b0);
    @(negedge clk) now("rst_hold", 8'hFF, 4'hF, 1'b0);
    rst = 1'b0;
    slot("post_rst", 8'hC0, 4'b1110, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
